rw_flow_ctrl: RTL and testbench

//  Parametrised read/write command sequencer between the command decoder, the memory

---
 rtl/rw_flow_ctrl_pkg.sv | 20 ++
 rtl/rw_flow_ctrl_if.sv | 33 +++
 rtl/rw_flow_timer.sv | 28 ++
 rtl/rw_flow_ctrl.sv | 130 +++++++++++++
 tb/tb_rw_flow_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rw_flow_ctrl_pkg.sv
// rtl/rw_flow_ctrl_pkg.sv - shared state encoding and access-direction constants
// for the read/write command sequencer.
package rw_flow_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] TX     = 2'd3;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_ACCESS = ACCESS,
    ST_SAMPLE = SAMPLE,
    ST_TX     = TX
  } state_t;

endpackage

// File: rtl/rw_flow_ctrl_if.sv
// rtl/rw_flow_ctrl_if.sv - command, memory and Tx signal bundle of the sequencer;
// the slave side belongs to rw_flow_ctrl, the master side to its environment.
interface rw_flow_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              ValidCmd;
  logic              RW;
  logic [ADDR_W-1:0] CmdAddr;
  logic [DATA_W-1:0] CmdData;
  logic [DATA_W-1:0] MemRdData;
  logic              TxDone;

  logic              AccessMem;
  logic              RWMem;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWrData;
  logic              SampleData;
  logic              TxData;
  logic [DATA_W-1:0] TxWord;

  modport master (
    output ValidCmd, RW, CmdAddr, CmdData, MemRdData, TxDone,
    input  AccessMem, RWMem, MemAddr, MemWrData, SampleData, TxData, TxWord
  );

  modport slave (
    input  ValidCmd, RW, CmdAddr, CmdData, MemRdData, TxDone,
    output AccessMem, RWMem, MemAddr, MemWrData, SampleData, TxData, TxWord
  );

endinterface

// File: rtl/rw_flow_timer.sv
// rtl/rw_flow_timer.sv - loadable down counter that stops at zero and flags it;
// load takes priority over counting.
module rw_flow_timer #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rw_flow_ctrl.sv
// rtl/rw_flow_ctrl.sv - one-command-at-a-time read/write sequencer: memory access,
// read-data sampling and supervised hand-off to the serial transmitter.
module rw_flow_ctrl
  import rw_flow_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2,
  parameter int TX_TO_W = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Active,
  input  logic            Mode,
  output logic            Busy,
  output logic            CmdDrop,
  output logic            TxErr,
  rw_flow_ctrl_if.slave   bus
);

  localparam int MEM_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

  // Timers are loaded one short because the state also spends its zero cycle there.
  localparam logic [MEM_W-1:0]   MEM_LOAD = MEM_W'(MEM_LAT - 1);
  localparam logic [TX_TO_W-1:0] TX_LOAD  = TX_TO_W'((2 ** TX_TO_W) - 2);

  state_t state;
  logic   accept;
  logic   mem_zero;
  logic   tx_zero;

  assign accept = (state == ST_IDLE) && bus.ValidCmd && Active && Mode;

  rw_flow_timer #(.W(MEM_W)) u_mem_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (accept),
    .load_val (MEM_LOAD),
    .en       (state == ST_ACCESS),
    .zero     (mem_zero)
  );

  rw_flow_timer #(.W(TX_TO_W)) u_tx_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (state == ST_SAMPLE),
    .load_val (TX_LOAD),
    .en       (state == ST_TX),
    .zero     (tx_zero)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= ST_IDLE;
      bus.AccessMem  <= 1'b0;
      bus.RWMem      <= RW_READ;
      bus.MemAddr    <= '0;
      bus.MemWrData  <= '0;
      bus.SampleData <= 1'b0;
      bus.TxData     <= 1'b0;
      bus.TxWord     <= '0;
      Busy           <= 1'b0;
      CmdDrop        <= 1'b0;
      TxErr          <= 1'b0;
    end else begin
      CmdDrop <= bus.ValidCmd && !accept;
      TxErr   <= 1'b0;

      if ((state != ST_IDLE) && !Active) begin
        state          <= ST_IDLE;
        bus.AccessMem  <= 1'b0;
        bus.RWMem      <= RW_READ;
        bus.SampleData <= 1'b0;
        bus.TxData     <= 1'b0;
        Busy           <= 1'b0;
        TxErr          <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              state         <= ST_ACCESS;
              bus.AccessMem <= 1'b1;
              bus.RWMem     <= bus.RW;
              bus.MemAddr   <= bus.CmdAddr;
              bus.MemWrData <= bus.CmdData;
              Busy          <= 1'b1;
            end
          end

          ST_ACCESS: begin
            if (mem_zero) begin
              bus.AccessMem <= 1'b0;
              if (bus.RWMem == RW_WRITE) begin
                state     <= ST_IDLE;
                bus.RWMem <= RW_READ;
                Busy      <= 1'b0;
              end else begin
                state          <= ST_SAMPLE;
                bus.SampleData <= 1'b1;
              end
            end
          end

          ST_SAMPLE: begin
            state          <= ST_TX;
            bus.SampleData <= 1'b0;
            bus.TxWord     <= bus.MemRdData;
            bus.TxData     <= 1'b1;
          end

          ST_TX: begin
            if (bus.TxDone) begin
              state      <= ST_IDLE;
              bus.TxData <= 1'b0;
              Busy       <= 1'b0;
            end else if (tx_zero) begin
              state      <= ST_IDLE;
              bus.TxData <= 1'b0;
              Busy       <= 1'b0;
              TxErr      <= 1'b1;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rw_flow_ctrl.sv
// tb/tb_rw_flow_ctrl.sv - directed bench for rw_flow_ctrl with MEM_LAT=2, TX_TO_W=4.
module tb_rw_flow_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  logic Active;
  logic Mode;
  logic Busy;
  logic CmdDrop;
  logic TxErr;

  int checks = 0;
  int errors = 0;

  rw_flow_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  rw_flow_ctrl #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .MEM_LAT (2),
    .TX_TO_W (4)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Active  (Active),
    .Mode    (Mode),
    .Busy    (Busy),
    .CmdDrop (CmdDrop),
    .TxErr   (TxErr),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic cmd(input logic rw, input logic [7:0] addr, input logic [7:0] data);
    bus.ValidCmd = 1'b1;
    bus.RW       = rw;
    bus.CmdAddr  = addr;
    bus.CmdData  = data;
    tick();
    bus.ValidCmd = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_access"}, bus.AccessMem, 0);
    chk({tag, "_rwmem"},  bus.RWMem, 0);
    chk({tag, "_addr"},   bus.MemAddr, 0);
    chk({tag, "_wrdata"}, bus.MemWrData, 0);
    chk({tag, "_sample"}, bus.SampleData, 0);
    chk({tag, "_txdata"}, bus.TxData, 0);
    chk({tag, "_txword"}, bus.TxWord, 0);
    chk({tag, "_busy"},   Busy, 0);
    chk({tag, "_drop"},   CmdDrop, 0);
    chk({tag, "_txerr"},  TxErr, 0);
  endtask

  initial begin
    Reset = 1'b1;
    Active = 1'b1;
    Mode = 1'b1;
    bus.ValidCmd = 1'b0;
    bus.RW = 1'b0;
    bus.CmdAddr = '0;
    bus.CmdData = '0;
    bus.MemRdData = '0;
    bus.TxDone = 1'b0;
    tick(2);
    chk_all_zero("rst");
    Reset = 1'b0;
    tick();

    // write, then a back-to-back write in the cycle Busy falls
    cmd(1'b1, 8'h3C, 8'h5A);
    chk("wr_access1", bus.AccessMem, 1);
    chk("wr_rwmem",   bus.RWMem, 1);
    chk("wr_busy",    Busy, 1);
    chk("wr_addr",    bus.MemAddr, 8'h3C);
    chk("wr_data",    bus.MemWrData, 8'h5A);
    tick();
    chk("wr_access2", bus.AccessMem, 1);
    chk("wr_txdata",  bus.TxData, 0);
    tick();
    chk("wr_access3", bus.AccessMem, 0);
    chk("wr_busy_end", Busy, 0);
    chk("wr_txdata_end", bus.TxData, 0);
    cmd(1'b1, 8'h40, 8'h11);
    chk("b2b_access", bus.AccessMem, 1);
    chk("b2b_addr",   bus.MemAddr, 8'h40);
    chk("b2b_drop",   CmdDrop, 0);
    tick(2);
    chk("b2b_busy_end", Busy, 0);

    // read with completion
    bus.MemRdData = 8'hA5;
    cmd(1'b0, 8'h12, 8'h00);
    chk("rd_access1", bus.AccessMem, 1);
    chk("rd_rwmem",   bus.RWMem, 0);
    tick();
    chk("rd_access2", bus.AccessMem, 1);
    chk("rd_sample_early", bus.SampleData, 0);
    tick();
    chk("rd_access3", bus.AccessMem, 0);
    chk("rd_sample",  bus.SampleData, 1);
    tick();
    chk("rd_sample_end", bus.SampleData, 0);
    chk("rd_txdata",  bus.TxData, 1);
    chk("rd_txword",  bus.TxWord, 8'hA5);
    tick();
    chk("rd_txdata_hold", bus.TxData, 1);
    bus.TxDone = 1'b1;
    tick();
    bus.TxDone = 1'b0;
    chk("rd_txdata_end", bus.TxData, 0);
    chk("rd_busy_end", Busy, 0);
    chk("rd_txerr", TxErr, 0);

    // command during TX is dropped
    bus.MemRdData = 8'h3C;
    cmd(1'b0, 8'h21, 8'h00);
    tick(3);
    chk("drop_txword0", bus.TxWord, 8'h3C);
    bus.MemRdData = 8'hFF;
    cmd(1'b1, 8'h77, 8'h99);
    chk("drop_pulse",  CmdDrop, 1);
    chk("drop_txword", bus.TxWord, 8'h3C);
    chk("drop_addr",   bus.MemAddr, 8'h21);
    chk("drop_txdata", bus.TxData, 1);
    tick();
    chk("drop_pulse_end", CmdDrop, 0);
    bus.TxDone = 1'b1;
    tick();
    bus.TxDone = 1'b0;
    chk("drop_busy_end", Busy, 0);
    chk("drop_txword_keep", bus.TxWord, 8'h3C);

    // commands refused in IDLE when inactive or not in command mode
    Mode = 1'b0;
    cmd(1'b1, 8'h55, 8'h66);
    chk("mode0_drop", CmdDrop, 1);
    chk("mode0_busy", Busy, 0);
    Mode = 1'b1;
    Active = 1'b0;
    cmd(1'b1, 8'h55, 8'h66);
    chk("act0_drop", CmdDrop, 1);
    chk("act0_access", bus.AccessMem, 0);
    Active = 1'b1;

    // Tx timeout: 15 cycles in TX
    cmd(1'b0, 8'h05, 8'h00);
    tick(3);
    chk("to_enter_tx", bus.TxData, 1);
    tick(14);
    chk("to_txdata_last", bus.TxData, 1);
    chk("to_txerr_early", TxErr, 0);
    tick();
    chk("to_txerr", TxErr, 1);
    chk("to_busy", Busy, 0);
    chk("to_txdata", bus.TxData, 0);
    tick();
    chk("to_txerr_end", TxErr, 0);

    // abort during the memory access of a read
    cmd(1'b0, 8'h33, 8'h00);
    Active = 1'b0;
    tick();
    chk("ab_access", bus.AccessMem, 0);
    chk("ab_txerr",  TxErr, 1);
    chk("ab_busy",   Busy, 0);
    tick();
    chk("ab_txerr_end", TxErr, 0);
    chk("ab_sample", bus.SampleData, 0);
    Active = 1'b1;
    tick();
    chk("ab_sample2", bus.SampleData, 0);

    // reset while in TX, then a fresh command
    bus.MemRdData = 8'h77;
    cmd(1'b0, 8'h44, 8'h00);
    tick(3);
    chk("rs_in_tx", bus.TxData, 1);
    #1;
    Reset = 1'b1;
    #1;
    chk_all_zero("rs");
    tick();
    Reset = 1'b0;
    tick();
    cmd(1'b1, 8'h6B, 8'hC3);
    chk("rs_new_access", bus.AccessMem, 1);
    chk("rs_new_addr",   bus.MemAddr, 8'h6B);
    chk("rs_new_busy",   Busy, 1);
    tick(2);
    chk("rs_new_done",   Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
